// File: rtl/add_share_pkg.sv
// add_share_pkg: shared types and constants for the add_share_arb slice.
//   DW          operand width of the shared fadder32
//   ID_MAX_W    widest requester ID this block supports (NREQ <= 16)
//   add_rsp_t   one registered response {id, cout, sum[, ovf]}
//   rsp_state_e response-register occupancy
// Build option: ADD_SHARE_OVF_EN adds the signed-overflow flag to add_rsp_t.
package add_share_pkg;

    localparam int DW       = 32;
    localparam int ID_MAX_W = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rsp_state_e;

    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        logic                cout;
        logic [DW-1:0]       sum;
`ifdef ADD_SHARE_OVF_EN
        logic                ovf;
`endif
    } add_rsp_t;

endpackage

// File: rtl/add_share_arb_rr_arb.sv
// rr_arb: round-robin grant, searching from ptr upward modulo N.
// Ports:
//   req      in   N    request vector
//   ptr      in   IW   highest-priority index for this cycle
//   en       in   1    grant allowed; with en=0 all outputs are 0
//   gnt      out  N    one-hot grant
//   gnt_idx  out  IW   index of the granted requester (0 when none)
//   any      out  1    a grant was made
module rr_arb #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    int idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (en && !any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/fadder32.sv
// fadder32: 32-bit full adder, {c_out, sum} = a + b + cin.
// Ports:
//   a, b   in   32   operands
//   cin    in   1    carry-in
//   sum    out  32   low 32 bits of the result
//   c_out  out  1    carry-out (bit 32)
module fadder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        c_out
);

    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {32'b0, cin};

endmodule

// File: rtl/add_share_arb.sv
// add_share_arb: shares one fadder32 among NREQ requesters.
// Round-robin arbitration issues at most one add per clock; the result is
// registered and returned on a single valid/ready channel tagged with the
// requester index. Sustained throughput is one add per clock.
// Ports:
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous reset, active-high
//   req_valid  in   NREQ     per-requester request valid
//   req_ready  out  NREQ     per-requester accept (at most one bit high)
//   req_a      in   NREQ*DW  operand A, requester i at [i*DW +: DW]
//   req_b      in   NREQ*DW  operand B, same packing
//   req_cin    in   NREQ     per-requester carry-in
//   rsp_valid  out  1        response register holds a result
//   rsp_ready  in   1        consumer accepts the response
//   rsp_id     out  ID_W     requester that owns the result
//   rsp_sum    out  DW       registered sum
//   rsp_cout   out  1        registered carry-out
//   rsp_ovf    out  1        registered signed overflow (ADD_SHARE_OVF_EN only)
// Build option: define ADD_SHARE_OVF_EN to add rsp_ovf.
//
// State | Meaning
// ------+-----------------------------------------------
// EMPTY | no result held, rsp_valid=0
// FULL  | result held in the response register, rsp_valid=1
module add_share_arb
    import add_share_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*DW-1:0]   req_a,
    input  logic [NREQ*DW-1:0]   req_b,
    input  logic [NREQ-1:0]      req_cin,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [DW-1:0]        rsp_sum,
    output logic                 rsp_cout
`ifdef ADD_SHARE_OVF_EN
    ,
    output logic                 rsp_ovf
`endif
);

    rsp_state_e      state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    add_rsp_t        rsp_q, rsp_d;

    logic            can_issue;
    logic            arb_en;
    logic [NREQ-1:0] gnt;
    logic [ID_W-1:0] gnt_idx;
    logic            issue;

    logic [DW-1:0]   op_a, op_b;
    logic            op_cin;
    logic [DW-1:0]   add_sum;
    logic            add_cout;

    // The slot frees up this cycle either because it is empty or because the
    // consumer drains it on this same edge; reset blocks all grants.
    assign can_issue = (state_q == EMPTY) | rsp_ready;
    assign arb_en    = can_issue & ~rst;

    rr_arb #(
        .N  (NREQ),
        .IW (ID_W)
    ) u_rr_arb (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (issue)
    );

    assign req_ready = gnt;

    assign op_a   = req_a[int'(gnt_idx)*DW +: DW];
    assign op_b   = req_b[int'(gnt_idx)*DW +: DW];
    assign op_cin = req_cin[gnt_idx];

    fadder32 u_fadder32 (
        .a     (op_a),
        .b     (op_b),
        .cin   (op_cin),
        .sum   (add_sum),
        .c_out (add_cout)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        rsp_d    = rsp_q;
        if (issue) begin
            state_d    = FULL;
            rr_ptr_d   = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            rsp_d.id   = ID_MAX_W'(gnt_idx);
            rsp_d.cout = add_cout;
            rsp_d.sum  = add_sum;
`ifdef ADD_SHARE_OVF_EN
            rsp_d.ovf  = (op_a[DW-1] == op_b[DW-1]) & (add_sum[DW-1] != op_a[DW-1]);
`endif
        end else if (state_q == FULL && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            rr_ptr_q <= '0;
            rsp_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            rsp_q    <= rsp_d;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_id    = rsp_q.id[ID_W-1:0];
    assign rsp_sum   = rsp_q.sum;
    assign rsp_cout  = rsp_q.cout;
`ifdef ADD_SHARE_OVF_EN
    assign rsp_ovf   = rsp_q.ovf;
`endif

    // The id field is sized for the largest NREQ; bits above ID_W stay zero.
    logic unused_id;
    assign unused_id = ^rsp_q.id;

endmodule

// File: tb/tb_add_share_arb.sv
module tb_add_share_arb;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int ID_W = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*DW-1:0]   req_a;
    logic [NREQ*DW-1:0]   req_b;
    logic [NREQ-1:0]      req_cin;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [DW-1:0]        rsp_sum;
    logic                 rsp_cout;
`ifdef ADD_SHARE_OVF_EN
    logic                 rsp_ovf;
`endif

    always #5 clk = ~clk;

    add_share_arb #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
`ifdef ADD_SHARE_OVF_EN
        ,
        .rsp_ovf   (rsp_ovf)
`endif
    );

    typedef struct {
        logic [ID_W-1:0] id;
        logic            cout;
        logic [DW-1:0]   sum;
        logic            ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic m_full   = 1'b0;
    int   m_ptr    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic cin);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
        req_cin[i]        = cin;
    endtask

    // One clock: at the falling edge compare DUT against the reference model,
    // then advance the model with the values present at the rising edge.
    task automatic cyc();
        logic [NREQ-1:0] exp_rdy;
        int              g;
        logic [31:0]     a, b;
        logic [32:0]     full;
        exp_t            e;
        @(negedge clk);
        exp_rdy = '0;
        g       = -1;
        if (!rst && (!m_full || rsp_ready)) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (m_ptr + k) % NREQ;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        check("rsp_valid", 64'(rsp_valid), 64'(m_full));
        if (m_full && exp_q.size() > 0) begin
            check("rsp_id",   64'(rsp_id),   64'(exp_q[0].id));
            check("rsp_sum",  64'(rsp_sum),  64'(exp_q[0].sum));
            check("rsp_cout", 64'(rsp_cout), 64'(exp_q[0].cout));
`ifdef ADD_SHARE_OVF_EN
            check("rsp_ovf",  64'(rsp_ovf),  64'(exp_q[0].ovf));
`endif
        end
        if (rst) begin
            m_full = 1'b0;
            m_ptr  = 0;
            exp_q.delete();
        end else begin
            if (m_full && rsp_ready) begin
                void'(exp_q.pop_front());
                m_full = 1'b0;
            end
            if (g >= 0) begin
                a      = req_a[g*DW +: DW];
                b      = req_b[g*DW +: DW];
                full   = {1'b0, a} + {1'b0, b} + 33'(req_cin[g]);
                e.id   = ID_W'(g);
                e.sum  = full[31:0];
                e.cout = full[32];
                e.ovf  = (a[31] == b[31]) && (full[31] != a[31]);
                exp_q.push_back(e);
                m_full = 1'b1;
                m_ptr  = (g + 1) % NREQ;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 32'(i * 11 + 1), 32'(i + 3), 1'b1);
        @(posedge clk);
        #1;

        // Reset held with every requester valid.
        for (int r = 0; r < 2; r++) begin
            cyc();
            check("reset_sum", 64'(rsp_sum), 64'd0);
            check("reset_id",  64'(rsp_id),  64'd0);
        end

        // Single op from requester 0.
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        cyc();
        set_req(0, 32'd128, 32'd64, 1'b1);
        req_valid = 4'b0001;
        cyc();
        req_valid = '0;
        check("single_valid", 64'(rsp_valid), 64'd1);
        check("single_id",    64'(rsp_id),    64'd0);
        check("single_sum",   64'(rsp_sum),   64'd193);
        check("single_cout",  64'(rsp_cout),  64'd0);
        cyc();

        // Realign the pointer to 0, then all four requesters valid.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 32'(i * 1000 + 7), 32'(i), i[0]);
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            check("rr_id",    64'(rsp_id),    64'(k % NREQ));
            check("rr_valid", 64'(rsp_valid), 64'd1);
        end
        req_valid = '0;
        cyc();

        // Backpressure: requester 2 result held, requester 3 waiting.
        set_req(2, 32'd33, 32'd89, 1'b0);
        req_valid = 4'b0100;
        cyc();
        rsp_ready = 1'b0;
        set_req(3, 32'd5, 32'd6, 1'b0);
        req_valid = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("bp_sum",   64'(rsp_sum),   64'd122);
            check("bp_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        cyc();
        req_valid = '0;
        check("b2b_valid", 64'(rsp_valid), 64'd1);
        check("b2b_id",    64'(rsp_id),    64'd3);
        check("b2b_sum",   64'(rsp_sum),   64'd11);

        // Carry wrap and signed overflow.
        set_req(1, 32'hFFFF_FFFF, 32'd0, 1'b1);
        req_valid = 4'b0010;
        cyc();
        check("wrap_sum",  64'(rsp_sum),  64'd0);
        check("wrap_cout", 64'(rsp_cout), 64'd1);
`ifdef ADD_SHARE_OVF_EN
        check("wrap_ovf",  64'(rsp_ovf),  64'd0);
`endif
        set_req(0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        req_valid = 4'b0001;
        cyc();
        check("ovf_sum",  64'(rsp_sum),  64'hFFFF_FFFE);
        check("ovf_cout", 64'(rsp_cout), 64'd0);
`ifdef ADD_SHARE_OVF_EN
        check("ovf_flag", 64'(rsp_ovf),  64'd1);
`endif

        // Mid-operation reset while FULL.
        req_valid = '0;
        rsp_ready = 1'b0;
        cyc();
        rst       = 1'b1;
        req_valid = '1;
        cyc();
        check("midrst_valid", 64'(rsp_valid), 64'd0);
        rst       = 1'b0;
        rsp_ready = 1'b1;
        set_req(0, 32'd1, 32'd2, 1'b0);
        cyc();
        check("midrst_id",  64'(rsp_id),  64'd0);
        check("midrst_sum", 64'(rsp_sum), 64'd3);

        // Random traffic against the reference model.
        for (int k = 0; k < 60; k++) begin
            req_valid = NREQ'($urandom_range(0, 15));
            rsp_ready = 1'($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) set_req(i, $urandom(), $urandom(), 1'($urandom_range(0, 1)));
            cyc();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        cyc();
        cyc();
        check("final_valid", 64'(rsp_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
